// File: rtl/seg_bcd_counter.sv
// 8-digit BCD run/hold counter with prescaled tick, load/clear and leading-zero blanking.
// Commands act at the next mclk edge, upd one edge later; no backpressure, every command is accepted.
module seg_bcd_counter #(
  parameter int TICK_DIV = 50000,
  parameter int BLANK_LZ = 1
) (
  input  logic        mclk,
  input  logic        rst,
  input  logic        start_stop,
  input  logic        clr,
  input  logic        load,
  input  logic [31:0] load_val,
  output logic [31:0] bcd_out,
  output logic [7:0]  blank,
  output logic        upd,
  output logic        ovf,
  output logic        running,
  output logic        load_err
);

  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] TERM = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;

  state_t        state;
  logic [PW-1:0] presc;
  logic          bcd_chg;
  logic [31:0]   fixed_val;
  logic          bad_digit;
  logic [31:0]   inc_val;
  logic          carry;
  logic          lz;

  // Illegal load digits are squashed to 0 and flagged.
  always_comb begin
    fixed_val = load_val;
    bad_digit = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (load_val[4*k +: 4] > 4'd9) begin
        fixed_val[4*k +: 4] = 4'd0;
        bad_digit = 1'b1;
      end
    end
  end

  always_comb begin
    inc_val = bcd_out;
    carry   = 1'b1;
    for (int k = 0; k < 8; k++) begin
      if (carry) begin
        if (bcd_out[4*k +: 4] == 4'd9) begin
          inc_val[4*k +: 4] = 4'd0;
        end else begin
          inc_val[4*k +: 4] = bcd_out[4*k +: 4] + 4'd1;
          carry = 1'b0;
        end
      end
    end
  end

  always_comb begin
    blank = 8'h00;
    lz    = 1'b1;
    for (int k = 7; k >= 1; k--) begin
      lz       = lz & (bcd_out[4*k +: 4] == 4'd0);
      blank[k] = lz;
    end
    if (BLANK_LZ == 0) blank = 8'h00;
  end

  assign running = (state == RUN);

  // bcd_chg marks an edge that changed bcd_out; upd replays it one edge later.
  always_ff @(posedge mclk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      presc    <= '0;
      bcd_out  <= '0;
      bcd_chg  <= 1'b0;
      upd      <= 1'b0;
      ovf      <= 1'b0;
      load_err <= 1'b0;
    end else begin
      upd      <= bcd_chg;
      bcd_chg  <= 1'b0;
      ovf      <= 1'b0;
      load_err <= 1'b0;
      if (clr) begin
        state   <= IDLE;
        presc   <= '0;
        bcd_out <= '0;
        bcd_chg <= (bcd_out != 32'd0);
      end else if (load) begin
        presc    <= '0;
        bcd_out  <= fixed_val;
        bcd_chg  <= (fixed_val != bcd_out);
        load_err <= bad_digit;
        if (state == IDLE && fixed_val != 32'd0) state <= HOLD;
      end else if (start_stop) begin
        if (state == RUN) begin
          state <= HOLD;
        end else begin
          state <= RUN;
          presc <= '0;
        end
      end else if (state == RUN) begin
        if (presc == TERM) begin
          presc   <= '0;
          bcd_out <= inc_val;
          bcd_chg <= 1'b1;
          ovf     <= carry;
        end else begin
          presc <= presc + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_seg_bcd_counter.sv
// Directed-vector bench for seg_bcd_counter at TICK_DIV=4, with a BLANK_LZ=0 twin sharing the inputs.
module tb_seg_bcd_counter;

  logic        mclk = 1'b0;
  logic        rst = 1'b0;
  logic        start_stop = 1'b0;
  logic        clr = 1'b0;
  logic        load = 1'b0;
  logic [31:0] load_val = 32'd0;

  logic [31:0] bcd_out, bcd_out_nl;
  logic [7:0]  blank, blank_nl;
  logic        upd, ovf, running, load_err;
  logic        upd_nl, ovf_nl, running_nl, load_err_nl;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 mclk = ~mclk;

  seg_bcd_counter #(.TICK_DIV(4), .BLANK_LZ(1)) dut (
    .mclk(mclk), .rst(rst), .start_stop(start_stop), .clr(clr), .load(load),
    .load_val(load_val), .bcd_out(bcd_out), .blank(blank), .upd(upd), .ovf(ovf),
    .running(running), .load_err(load_err)
  );

  seg_bcd_counter #(.TICK_DIV(4), .BLANK_LZ(0)) dut_nl (
    .mclk(mclk), .rst(rst), .start_stop(start_stop), .clr(clr), .load(load),
    .load_val(load_val), .bcd_out(bcd_out_nl), .blank(blank_nl), .upd(upd_nl), .ovf(ovf_nl),
    .running(running_nl), .load_err(load_err_nl)
  );

  typedef struct {
    logic        ss, cl, ld;
    logic [31:0] lv;
    logic [31:0] e_bcd;
    logic        e_run, e_upd, e_ovf, e_err;
    logic [7:0]  e_blank;
  } vec_t;

  vec_t tv[$];

  task automatic add(input logic ss, input logic cl, input logic ld, input logic [31:0] lv,
                     input logic [31:0] e_bcd, input logic e_run, input logic e_upd,
                     input logic e_ovf, input logic e_err, input logic [7:0] e_blank);
    vec_t v;
    v.ss = ss; v.cl = cl; v.ld = ld; v.lv = lv;
    v.e_bcd = e_bcd; v.e_run = e_run; v.e_upd = e_upd;
    v.e_ovf = e_ovf; v.e_err = e_err; v.e_blank = e_blank;
    tv.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [31:0] e_bcd, input logic e_run,
                         input logic e_upd, input logic e_ovf, input logic e_err,
                         input logic [7:0] e_blank);
    chk({tag, " bcd_out"}, bcd_out, e_bcd);
    chk({tag, " running"}, 32'(running), 32'(e_run));
    chk({tag, " upd"}, 32'(upd), 32'(e_upd));
    chk({tag, " ovf"}, 32'(ovf), 32'(e_ovf));
    chk({tag, " load_err"}, 32'(load_err), 32'(e_err));
    chk({tag, " blank"}, 32'(blank), 32'(e_blank));
    chk({tag, " blank_nolz"}, 32'(blank_nl), 32'd0);
  endtask

  initial begin
    //   ss cl ld load_val       bcd_out      run upd ovf err blank
    add(0, 0, 1, 32'h00000099, 32'h00000099, 0, 0, 0, 0, 8'hFC); // load in IDLE -> HOLD
    add(0, 0, 0, 32'h0,        32'h00000099, 0, 1, 0, 0, 8'hFC);
    add(1, 0, 0, 32'h0,        32'h00000099, 1, 0, 0, 0, 8'hFC); // HOLD -> RUN
    add(0, 0, 0, 32'h0,        32'h00000099, 1, 0, 0, 0, 8'hFC);
    add(0, 0, 0, 32'h0,        32'h00000099, 1, 0, 0, 0, 8'hFC);
    add(0, 0, 0, 32'h0,        32'h00000099, 1, 0, 0, 0, 8'hFC);
    add(0, 0, 0, 32'h0,        32'h00000100, 1, 0, 0, 0, 8'hF8); // tick with carry
    add(0, 0, 0, 32'h0,        32'h00000100, 1, 1, 0, 0, 8'hF8);
    add(1, 0, 0, 32'h0,        32'h00000100, 0, 0, 0, 0, 8'hF8); // RUN -> HOLD
    add(0, 0, 1, 32'h1234F678, 32'h12340678, 0, 0, 0, 1, 8'h00); // bad digit squashed
    add(0, 0, 0, 32'h0,        32'h12340678, 0, 1, 0, 0, 8'h00);
    add(0, 0, 1, 32'h12340678, 32'h12340678, 0, 0, 0, 0, 8'h00); // same value reloaded
    add(0, 0, 0, 32'h0,        32'h12340678, 0, 0, 0, 0, 8'h00);
    add(1, 1, 0, 32'h0,        32'h00000000, 0, 0, 0, 0, 8'hFE); // clr beats start_stop
    add(0, 0, 0, 32'h0,        32'h00000000, 0, 1, 0, 0, 8'hFE);
    add(0, 1, 0, 32'h0,        32'h00000000, 0, 0, 0, 0, 8'hFE); // clr of zero
    add(0, 0, 0, 32'h0,        32'h00000000, 0, 0, 0, 0, 8'hFE);
    add(1, 0, 1, 32'h00000000, 32'h00000000, 0, 0, 0, 0, 8'hFE); // zero load beats start_stop
    add(0, 0, 1, 32'h99999999, 32'h99999999, 0, 0, 0, 0, 8'h00);
    add(1, 0, 0, 32'h0,        32'h99999999, 1, 1, 0, 0, 8'h00);
    add(0, 0, 0, 32'h0,        32'h99999999, 1, 0, 0, 0, 8'h00);
    add(0, 0, 0, 32'h0,        32'h99999999, 1, 0, 0, 0, 8'h00);
    add(0, 0, 0, 32'h0,        32'h99999999, 1, 0, 0, 0, 8'h00);
    add(0, 0, 0, 32'h0,        32'h00000000, 1, 0, 1, 0, 8'hFE); // wrap
    add(0, 0, 0, 32'h0,        32'h00000000, 1, 1, 0, 0, 8'hFE);
    add(1, 1, 1, 32'h00000005, 32'h00000000, 0, 0, 0, 0, 8'hFE); // clr in RUN wins
    add(1, 0, 0, 32'h0,        32'h00000000, 1, 0, 0, 0, 8'hFE);
    add(0, 0, 1, 32'h00000042, 32'h00000042, 1, 0, 0, 0, 8'hFC); // load in RUN stays RUN
    add(0, 0, 0, 32'h0,        32'h00000042, 1, 1, 0, 0, 8'hFC);
    add(0, 0, 0, 32'h0,        32'h00000042, 1, 0, 0, 0, 8'hFC);
    add(0, 0, 0, 32'h0,        32'h00000042, 1, 0, 0, 0, 8'hFC);
    add(0, 0, 0, 32'h0,        32'h00000043, 1, 0, 0, 0, 8'hFC);
    add(1, 0, 1, 32'h09999999, 32'h09999999, 1, 1, 0, 0, 8'h80); // load beats start_stop
    add(0, 0, 0, 32'h0,        32'h09999999, 1, 1, 0, 0, 8'h80);
    add(0, 0, 0, 32'h0,        32'h09999999, 1, 0, 0, 0, 8'h80);
    add(0, 0, 0, 32'h0,        32'h09999999, 1, 0, 0, 0, 8'h80);
    add(0, 0, 0, 32'h0,        32'h10000000, 1, 0, 0, 0, 8'h00);

    #1;
    chk_all("reset", 32'h0, 0, 0, 0, 0, 8'hFE);
    @(negedge mclk);
    rst = 1'b1;

    foreach (tv[i]) begin
      @(negedge mclk);
      start_stop = tv[i].ss;
      clr        = tv[i].cl;
      load       = tv[i].ld;
      load_val   = tv[i].lv;
      @(posedge mclk);
      #1;
      start_stop = 1'b0;
      clr        = 1'b0;
      load       = 1'b0;
      load_val   = 32'h0;
      chk_all($sformatf("v%0d", i), tv[i].e_bcd, tv[i].e_run, tv[i].e_upd,
              tv[i].e_ovf, tv[i].e_err, tv[i].e_blank);
    end

    // Asynchronous reset between edges while upd is high and the count is running.
    @(posedge mclk);
    #2;
    chk("pre_rst upd", 32'(upd), 32'd1);
    rst = 1'b0;
    #1;
    chk_all("async_rst", 32'h0, 0, 0, 0, 0, 8'hFE);
    for (int c = 0; c < 3; c++) begin
      @(posedge mclk);
      #1;
      chk_all($sformatf("in_rst%0d", c), 32'h0, 0, 0, 0, 0, 8'hFE);
    end

    // Command in the first cycle after release, then first tick after four edges.
    @(negedge mclk);
    rst = 1'b1;
    start_stop = 1'b1;
    @(posedge mclk);
    #1;
    start_stop = 1'b0;
    chk_all("rel_start", 32'h0, 1, 0, 0, 0, 8'hFE);
    for (int c = 1; c <= 3; c++) begin
      @(posedge mclk);
      #1;
      chk_all($sformatf("rel_wait%0d", c), 32'h0, 1, 0, 0, 0, 8'hFE);
    end
    @(posedge mclk);
    #1;
    chk_all("rel_tick", 32'h1, 1, 0, 0, 0, 8'hFE);
    @(posedge mclk);
    #1;
    chk_all("rel_upd", 32'h1, 1, 1, 0, 0, 8'hFE);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/seg_bcd_counter.md
SEG_BCD_COUNTER -- requirements
Module: seg_bcd_counter

Interface
REQ-001 The block SHALL have parameter TICK_DIV, default 50000, meaning mclk cycles per count increment (legal range 2..2^20).
REQ-002 The block SHALL have parameter BLANK_LZ, default 1, meaning that leading-zero blanking is enabled when the value is 1.
REQ-003 Port mclk  input  1  system clock; all state changes on rising edge.
REQ-004 Port rst  input  1  reset, asynchronous, active-low (rst=0 resets).
REQ-005 Port start_stop  input  1  one-cycle command pulse that toggles run/hold.
REQ-006 Port clr  input  1  one-cycle synchronous clear command.
REQ-007 Port load  input  1  one-cycle synchronous load command.
REQ-008 Port load_val  input  32  packed BCD load value; digit k occupies bits [4k+3:4k], with digit 0 the least significant.
REQ-009 Port bcd_out  output  32  packed BCD count for the downstream 8-digit segment scanner.
REQ-010 Port blank  output  8  per-digit blank request; bit k=1 means digit k shall be dark.
REQ-011 Port upd  output  1  one-cycle pulse in the cycle after bcd_out changes.
REQ-012 Port ovf  output  1  one-cycle pulse on wrap from 99999999 to 00000000.
REQ-013 Port running  output  1  high while the FSM is in RUN.
REQ-014 Port load_err  output  1  one-cycle pulse when load_val contains a digit greater than 9.

Function
REQ-015 The FSM SHALL have exactly three states: IDLE (count is zero and stopped), RUN, and HOLD (count is nonzero and stopped).
REQ-016 The FSM transitions SHALL be:
- IDLE -start_stop-> RUN
- RUN -start_stop-> HOLD
- HOLD -start_stop-> RUN
- any state -clr-> IDLE
- IDLE -load (nonzero value)-> HOLD
- RUN/HOLD -load-> unchanged state
REQ-017 Command priority within a single cycle SHALL be clr > load > start_stop > tick; lower-priority events in that cycle SHALL be discarded.
REQ-018 The prescaler SHALL count 0..TICK_DIV-1 only in RUN and assert an internal tick when it reaches TICK_DIV-1, then wrap to 0.
REQ-019 The prescaler SHALL reset to 0 on clr, on load, and on any entry into RUN.
REQ-020 In HOLD the prescaler SHALL freeze at its current value.
REQ-021 On tick, bcd_out SHALL increment by 1 in decimal with a ripple carry: a digit at 9 becomes 0 and carries to the next digit; no digit SHALL ever hold A-F.
REQ-022 On a tick with bcd_out=99999999, bcd_out SHALL become 00000000, ovf SHALL pulse in the same cycle that bcd_out becomes zero, and the FSM SHALL remain in RUN.
REQ-023 On load, bcd_out SHALL take load_val on the next edge, except that each digit greater than 9 SHALL be replaced by 0 and load_err SHALL pulse for one cycle.
REQ-024 A load with an all-zero (after correction) value in IDLE SHALL leave the FSM in IDLE.
REQ-025 On clr, bcd_out SHALL become 0.
REQ-026 upd SHALL be registered and SHALL pulse exactly one cycle after any edge at which bcd_out changed value.
REQ-027 upd SHALL NOT pulse if a load or clr writes the value already held.
REQ-028 blank SHALL be combinational from bcd_out.
REQ-029 When BLANK_LZ=1, blank bit k SHALL be 1 iff all digits k..7 are 0 and k>0; digit 0 SHALL never be blanked.
REQ-030 When BLANK_LZ=0, blank SHALL be 8'h00.
REQ-031 Latency SHALL be: command pulse -> state, bcd_out and running change at the next rising edge; upd follows one edge later.

Reset
REQ-032 While rst=0, the outputs SHALL be forced immediately regardless of mclk: bcd_out=0, blank=8'hFE (BLANK_LZ=1), upd=0, ovf=0, load_err=0, running=0; the FSM SHALL be in IDLE and the prescaler at 0.
REQ-033 On rst deassertion the block SHALL resume in IDLE; a command pulse present in the first cycle after deassertion SHALL be honoured.
REQ-034 Reset asserted mid-RUN SHALL discard the count and the prescaler with no ovf or upd pulse.

Verification
REQ-035 Scenario: TICK_DIV=4, reset, start_stop pulse -> running=1; bcd_out=00000001 exactly 4 cycles after the pulse edge; upd one cycle later; blank=8'hFE.
REQ-036 Scenario: load 00000099 in HOLD, start_stop, one tick -> bcd_out=00000100, blank=8'hF8.
REQ-037 Scenario: load 99999999, run one tick -> bcd_out=00000000, ovf single pulse, running stays 1.
REQ-038 Scenario: load 1234F678 -> bcd_out=12340678, load_err single pulse, FSM in HOLD.
REQ-039 Scenario: clr and start_stop asserted in the same cycle while in RUN -> IDLE, bcd_out=0, running=0.
REQ-040 Scenario: rst driven low asynchronously mid-count between mclk edges -> outputs reach reset values before the next mclk edge, with no upd or ovf pulse.
